// File: rtl/stream_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stream_channel_arbiter
// Brief    : Round-robin merge of N_CH AXI-Stream sources into one stream.
//            The channel index goes out on tuser. ARB_FRAME_LOCK_EN (define)
//            holds the grant on one channel until its tlast beat.
// Revision : 1.0 - initial release
// ============================================================================
module stream_channel_arbiter #(
    parameter int N_CH   = 8,
    parameter int DATA_W = 24,
    parameter int USER_W = 3
) (
    input  logic                     s_axis_aclk,
    input  logic                     s_axis_aresetn,
    input  logic [N_CH-1:0]          ch_enable,
    input  logic [N_CH*DATA_W-1:0]   s_axis_tdata,
    input  logic [N_CH-1:0]          s_axis_tvalid,
    output logic [N_CH-1:0]          s_axis_tready,
    input  logic [N_CH-1:0]          s_axis_tlast,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [USER_W-1:0]        m_axis_tuser,
    output logic                     m_axis_tlast,
    output logic [USER_W-1:0]        grant_ch
);

    localparam logic [USER_W-1:0] c_GRANT_RST = USER_W'(N_CH - 1);

    logic [N_CH-1:0]   w_req;
    logic              w_load;
    logic              w_any_req;
    logic [USER_W-1:0] w_winner;
    logic              w_xfer;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_last;

    logic [DATA_W-1:0] r_tdata;
    logic              r_tvalid;
    logic [USER_W-1:0] r_tuser;
    logic              r_tlast;
    logic [USER_W-1:0] r_grant_ch;

    assign w_req  = s_axis_tvalid & ch_enable;
    assign w_load = !r_tvalid || m_axis_tready;
    assign w_xfer = w_load && w_any_req;

`ifdef ARB_FRAME_LOCK_EN
    localparam logic [0:0] c_ST_OPEN   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    logic [0:0] r_lock_state;
    logic [0:0] w_lock_next;
    logic       w_lock_active;

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_lock_state <= c_ST_OPEN;
        end else begin
            r_lock_state <= w_lock_next;
        end
    end

    // Disabling the locked channel drops the lock in the same cycle.
    always_comb begin
        w_lock_active = (r_lock_state == c_ST_LOCKED) && ch_enable[r_grant_ch];
    end

    always_comb begin
        w_lock_next = w_lock_active ? c_ST_LOCKED : c_ST_OPEN;
        if (w_xfer) begin
            w_lock_next = w_sel_last ? c_ST_OPEN : c_ST_LOCKED;
        end
    end
`endif

    // Search starts one past the last grant and wraps at N_CH.
    always_comb begin
        int idx;
        idx       = 0;
        w_any_req = 1'b0;
        w_winner  = '0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = int'(r_grant_ch) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!w_any_req && w_req[USER_W'(idx)]) begin
                w_any_req = 1'b1;
                w_winner  = USER_W'(idx);
            end
        end
`ifdef ARB_FRAME_LOCK_EN
        if (w_lock_active) begin
            w_any_req = w_req[r_grant_ch];
            w_winner  = r_grant_ch;
        end
`endif
    end

    always_comb begin
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_winner == USER_W'(i)) begin
                w_sel_data = s_axis_tdata[i*DATA_W +: DATA_W];
                w_sel_last = s_axis_tlast[i];
            end
        end
    end

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_tready
            assign s_axis_tready[i] = s_axis_aresetn && w_xfer &&
                                      (w_winner == USER_W'(i));
        end
    endgenerate

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_tuser    <= '0;
            r_tlast    <= 1'b0;
            r_grant_ch <= c_GRANT_RST;
        end else if (w_xfer) begin
            r_tdata    <= w_sel_data;
            r_tvalid   <= 1'b1;
            r_tuser    <= w_winner;
            r_tlast    <= w_sel_last;
            r_grant_ch <= w_winner;
        end else if (m_axis_tready) begin
            r_tvalid   <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tuser  = r_tuser;
    assign m_axis_tlast  = r_tlast;
    assign grant_ch      = r_grant_ch;

endmodule
`default_nettype wire

// File: tb/tb_stream_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_channel_arbiter
// Brief    : Directed scoreboard bench for stream_channel_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_channel_arbiter;

    localparam int N_CH   = 8;
    localparam int DATA_W = 24;
    localparam int USER_W = 3;

    logic                   clk;
    logic                   aresetn;
    logic [N_CH-1:0]        ch_enable;
    logic [N_CH*DATA_W-1:0] s_tdata;
    logic [N_CH-1:0]        s_tvalid;
    logic [N_CH-1:0]        s_tready;
    logic [N_CH-1:0]        s_tlast;
    logic [DATA_W-1:0]      m_tdata;
    logic                   m_tvalid;
    logic                   m_tready;
    logic [USER_W-1:0]      m_tuser;
    logic                   m_tlast;
    logic [USER_W-1:0]      grant_ch;

    stream_channel_arbiter #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W),
        .USER_W (USER_W)
    ) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (aresetn),
        .ch_enable      (ch_enable),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .s_axis_tlast   (s_tlast),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .m_axis_tuser   (m_tuser),
        .m_axis_tlast   (m_tlast),
        .grant_ch       (grant_ch)
    );

    typedef struct {
        int user;
        int data;
        int last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_b;
    int    n_vec = 0;
    int    n_err = 0;

`ifdef ARB_FRAME_LOCK_EN
    int exp5_ch[8]   = '{1, 1, 1, 1, 2, 2, 2, 2};
    int exp5_last[8] = '{0, 0, 0, 1, 1, 1, 1, 1};
`else
    int exp5_ch[8]   = '{1, 2, 1, 2, 1, 2, 1, 2};
    int exp5_last[8] = '{0, 1, 0, 1, 0, 1, 1, 1};
`endif
    int ph4_order[4] = '{0, 2, 5, 7};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_beat(input int ch, input int data, input int last);
        beat_t b;
        b.user = ch;
        b.data = data;
        b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output beat is popped and compared.
    always @(negedge clk) begin
        if (aresetn && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got tuser %0d, expected no beat", m_tuser);
            end else begin
                mon_b = exp_q.pop_front();
                check("beat_tuser", 32'(m_tuser), 32'(mon_b.user));
                check("beat_tdata", 32'(m_tdata), 32'(mon_b.data));
                check("beat_tlast", 32'(m_tlast), 32'(mon_b.last));
            end
        end
    end

    initial begin
        int ch;
        int ch1_sent;
        int took;
        int wait_cyc;

        aresetn   = 1'b0;
        ch_enable = 8'hFF;
        s_tvalid  = 8'hFF;
        s_tlast   = 8'hFF;
        m_tready  = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            s_tdata[i*DATA_W +: DATA_W] = DATA_W'(i * 100);
        end

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_m_tvalid", 32'(m_tvalid), 0);
        check("rst_m_tdata",  32'(m_tdata),  0);
        check("rst_m_tuser",  32'(m_tuser),  0);
        check("rst_m_tlast",  32'(m_tlast),  0);
        check("rst_grant_ch", 32'(grant_ch), 7);
        check("rst_s_tready", 32'(s_tready), 0);
        aresetn = 1'b1;
        #1;
        check("rel_s_tready", 32'(s_tready), 32'h01);
        check("rel_m_tvalid", 32'(m_tvalid), 0);

        // Full rotation, all channels valid
        for (int k = 0; k < 16; k++) begin
            check("rot_s_tready", 32'(s_tready), 32'(1 << (k % 8)));
            expect_beat(k % 8, (k % 8) * 100, 1);
            step();
        end

        // Single requester, channel 3
        s_tvalid = 8'h08;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("single_s_tready", 32'(s_tready), 32'h08);
            if (i < 3) expect_beat(3, 300, 1);
            step();
        end

        // Hold a beat, then async reset mid-stream
        m_tready = 1'b0;
        s_tvalid = 8'hFF;
        #1;
        check("held_m_tvalid", 32'(m_tvalid), 1);
        check("held_m_tuser",  32'(m_tuser),  3);
        check("held_m_tdata",  32'(m_tdata),  300);
        aresetn = 1'b0;
        #1;
        check("async_m_tvalid", 32'(m_tvalid), 0);
        check("async_s_tready", 32'(s_tready), 0);
        check("async_grant_ch", 32'(grant_ch), 7);
        step();
        step();
        aresetn  = 1'b1;
        m_tready = 1'b1;
        #1;
        check("rel2_s_tready", 32'(s_tready), 32'h01);

        // Back-pressure: first beat held for 5 cycles
        expect_beat(0, 0, 1);
        step();
        m_tready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("stall_s_tready", 32'(s_tready), 0);
            check("stall_m_tvalid", 32'(m_tvalid), 1);
            check("stall_m_tuser",  32'(m_tuser),  0);
            check("stall_m_tdata",  32'(m_tdata),  0);
            step();
        end
        m_tready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            expect_beat(k, k * 100, 1);
            step();
        end

        // Enable mask 1010_0101
        ch_enable = 8'hA5;
        for (int j = 0; j < 8; j++) begin
            ch = ph4_order[j % 4];
            #1;
            check("mask_s_tready", 32'(s_tready), 32'(1 << ch));
            expect_beat(ch, ch * 100, 1);
            step();
        end

        // ch1 4-beat frame against continuously valid ch2
        ch_enable = 8'hFF;
        s_tvalid  = 8'h06;
        ch1_sent  = 0;
        for (int j = 0; j < 8; j++) begin
            s_tvalid[1] = (ch1_sent < 4);
            s_tlast[1]  = (ch1_sent == 3);
            #1;
            took = int'(s_tready[1]);
            check("frame_s_tready", 32'(s_tready), 32'(1 << exp5_ch[j]));
            expect_beat(exp5_ch[j], exp5_ch[j] * 100, exp5_last[j]);
            @(posedge clk);
            if (took != 0) ch1_sent++;
            #1;
        end
        s_tvalid = 8'h00;

        // Drain with a bounded wait
        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 20) begin
            step();
            wait_cyc++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 0);
        step();
        check("idle_m_tvalid", 32'(m_tvalid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
